// File: rtl/port_wr_sram_matcher_if.sv
// Match handshake between a write-port frontend and its SRAM matcher.
//   master : frontend side, drives the request and the end-of-packet release
//   slave  : matcher side, returns match_suc / matched_* / sweep_fail
interface port_wr_sram_matcher_if #(
  parameter int unsigned SRAM_IDX_W = 5
);
  logic                  match_enable;
  logic [3:0]            new_dest_port;
  logic [8:0]            new_length;
  logic                  end_of_packet;
  logic                  match_suc;
  logic [SRAM_IDX_W-1:0] matched_sram;
  logic [3:0]            matched_dest;
  logic                  matched_vld;
  logic                  sweep_fail;

  modport master (
    output match_enable, new_dest_port, new_length, end_of_packet,
    input  match_suc, matched_sram, matched_dest, matched_vld, sweep_fail
  );

  modport slave (
    input  match_enable, new_dest_port, new_length, end_of_packet,
    output match_suc, matched_sram, matched_dest, matched_vld, sweep_fail
  );
endinterface

// File: rtl/port_wr_sram_matcher.sv
// Per-write-port SRAM bank matcher. Takes a match request from the frontend,
// scans the shared banks round-robin (one candidate per clock) for a bank that
// is accessible and has enough free pages, pulses match_suc, and holds the bank
// locked until end_of_packet.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   mif         : slave side of the frontend match handshake
//   free_space  : flattened per-bank free-page counts, bank i at [i*FREE_W +: FREE_W]
//   accessible  : per-bank claim permission for this port, sampled live
module port_wr_sram_matcher #(
  parameter int unsigned SRAM_CNT        = 32,
  parameter int unsigned SRAM_IDX_W      = 5,
  parameter int unsigned FREE_W          = 11,
  parameter int unsigned PAGE_WORDS_LOG2 = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  port_wr_sram_matcher_if.slave      mif,
  input  logic [SRAM_CNT*FREE_W-1:0] free_space,
  input  logic [SRAM_CNT-1:0]        accessible
);

  localparam int unsigned NeedW     = 10;
  localparam int unsigned CmpW      = (FREE_W > NeedW) ? FREE_W : NeedW;
  localparam logic [NeedW-1:0] PageRound = NeedW'((1 << PAGE_WORDS_LOG2) - 1);
  localparam logic [SRAM_IDX_W-1:0] LastIdx = SRAM_IDX_W'(SRAM_CNT - 1);

  typedef enum logic [1:0] {StIdle, StScan, StLocked} state_e;

  state_e                state_q, state_d;
  logic [SRAM_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRAM_IDX_W-1:0] cursor_q, cursor_d;
  logic [SRAM_IDX_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [NeedW-1:0]      need_q, need_d;
  logic [3:0]            dest_q, dest_d;
  logic [SRAM_IDX_W-1:0] sram_q, sram_d;
  logic                  vld_q, vld_d;
  logic                  suc_q, suc_d;
  logic                  fail_q, fail_d;
  // Registered compare stage: keeps the wide bank mux and compare off the FSM path.
  logic                  cmp_vld_q, cmp_vld_d;
  logic                  cmp_hit_q, cmp_hit_d;
  logic [SRAM_IDX_W-1:0] cmp_idx_q, cmp_idx_d;

  logic [FREE_W-1:0] free_arr [SRAM_CNT];
  logic [NeedW-1:0]  need_sum, need_calc;
  logic [CmpW-1:0]   free_ext, need_ext;
  logic              cand_hit;

  function automatic logic [SRAM_IDX_W-1:0] next_idx(input logic [SRAM_IDX_W-1:0] idx);
    if (idx == LastIdx) return '0;
    return idx + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < SRAM_CNT; i++) begin
      free_arr[i] = free_space[i*FREE_W +: FREE_W];
    end
  end

  // Page count rounded up; 9-bit length plus rounding fits in 10 bits.
  assign need_sum  = {1'b0, mif.new_length} + PageRound;
  assign need_calc = need_sum >> PAGE_WORDS_LOG2;

  assign free_ext = CmpW'(free_arr[cursor_q]);
  assign need_ext = CmpW'(need_q);
  assign cand_hit = accessible[cursor_q] && (free_ext >= need_ext);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cursor_d    = cursor_q;
    sweep_cnt_d = sweep_cnt_q;
    need_d      = need_q;
    dest_d      = dest_q;
    sram_d      = sram_q;
    vld_d       = vld_q;
    suc_d       = 1'b0;
    fail_d      = 1'b0;
    cmp_vld_d   = 1'b0;
    cmp_hit_d   = 1'b0;
    cmp_idx_d   = cmp_idx_q;

    unique case (state_q)
      StIdle: begin
        if (mif.match_enable) begin
          need_d      = need_calc;
          dest_d      = mif.new_dest_port;
          cursor_d    = rr_ptr_q;
          sweep_cnt_d = '0;
          state_d     = StScan;
        end
      end
      StScan: begin
        if (!mif.match_enable) begin
          state_d = StIdle;
        end else if (cmp_vld_q && cmp_hit_q) begin
          suc_d   = 1'b1;
          sram_d  = cmp_idx_q;
          vld_d   = 1'b1;
          state_d = StLocked;
        end else begin
          if (cmp_vld_q) begin
            // Registered miss: count it toward the current sweep.
            if (sweep_cnt_q == LastIdx) begin
              fail_d      = 1'b1;
              sweep_cnt_d = '0;
            end else begin
              sweep_cnt_d = sweep_cnt_q + 1'b1;
            end
          end
          cmp_vld_d = 1'b1;
          cmp_hit_d = cand_hit;
          cmp_idx_d = cursor_q;
          cursor_d  = next_idx(cursor_q);
        end
      end
      StLocked: begin
        if (mif.end_of_packet) begin
          vld_d    = 1'b0;
          rr_ptr_d = next_idx(sram_q);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      cursor_q    <= '0;
      sweep_cnt_q <= '0;
      need_q      <= '0;
      dest_q      <= '0;
      sram_q      <= '0;
      vld_q       <= 1'b0;
      suc_q       <= 1'b0;
      fail_q      <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_hit_q   <= 1'b0;
      cmp_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cursor_q    <= cursor_d;
      sweep_cnt_q <= sweep_cnt_d;
      need_q      <= need_d;
      dest_q      <= dest_d;
      sram_q      <= sram_d;
      vld_q       <= vld_d;
      suc_q       <= suc_d;
      fail_q      <= fail_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_hit_q   <= cmp_hit_d;
      cmp_idx_q   <= cmp_idx_d;
    end
  end

  assign mif.match_suc    = suc_q;
  assign mif.matched_sram = sram_q;
  assign mif.matched_dest = dest_q;
  assign mif.matched_vld  = vld_q;
  assign mif.sweep_fail   = fail_q;

endmodule

// File: tb/tb_port_wr_sram_matcher.sv
// Self-checking bench for port_wr_sram_matcher: boundary table, hand-written
// corner sequences, and randomized requests against a request-level model.
module tb_port_wr_sram_matcher;

  localparam int NBank = 32;
  localparam int FreeW = 11;

  logic                   clk;
  logic                   rst_n;
  logic [NBank-1:0]       acc_v;
  logic [FreeW-1:0]       free_v [NBank];
  logic [NBank*FreeW-1:0] free_space_w;

  int n_cmp;
  int n_bad;
  int rr_m;

  port_wr_sram_matcher_if #(.SRAM_IDX_W(5)) mif ();

  port_wr_sram_matcher #(
    .SRAM_CNT       (32),
    .SRAM_IDX_W     (5),
    .FREE_W         (11),
    .PAGE_WORDS_LOG2(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mif       (mif.slave),
    .free_space(free_space_w),
    .accessible(acc_v)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    free_space_w = '0;
    for (int i = 0; i < NBank; i++) free_space_w[i*FreeW +: FreeW] = free_v[i];
  end

  typedef struct {
    logic [8:0]  len;
    logic [10:0] free;
    int          bank;
    bit          exp_hit;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_all(input logic [NBank-1:0] acc, input int free);
    acc_v = acc;
    for (int i = 0; i < NBank; i++) free_v[i] = FreeW'(free);
  endtask

  // Model: first eligible bank in round-robin order from rr_m decides the
  // latency (2 + offset); no eligible bank means a sweep_fail every 32 cycles.
  task automatic run_request(input logic [8:0] len, input logic [3:0] dest, input int miss_cycles,
                             input bit keep_lock, output bit got);
    int  need;
    int  idx;
    int  lat;
    int  n_sweep;
    int  exp_sweep;
    bit  found;
    need  = (int'(len) + 7) / 8;
    found = 0;
    idx   = 0;
    lat   = 0;
    for (int k = 0; k < NBank; k++) begin
      int b;
      b = (rr_m + k) % NBank;
      if (!found && acc_v[b] && int'(free_v[b]) >= need) begin
        found = 1;
        idx   = b;
        lat   = 2 + k;
      end
    end
    got     = 0;
    n_sweep = 0;
    mif.new_length    = len;
    mif.new_dest_port = dest;
    mif.match_enable  = 1'b1;
    tick();
    if (found) begin
      for (int c = 1; c <= lat + 3 && !got; c++) begin
        tick();
        if (mif.sweep_fail) n_sweep++;
        if (mif.match_suc) begin
          got = 1;
          check("latency", c, lat);
          check("matched_sram", 32'(mif.matched_sram), idx);
          check("matched_dest", 32'(mif.matched_dest), 32'(dest));
          check("matched_vld", 32'(mif.matched_vld), 1);
        end
      end
      check("hit_seen", 32'(got), 1);
      check("sweep_during_hit", n_sweep, 0);
      if (!got) begin
        mif.match_enable = 1'b0;
        tick();
      end else if (!keep_lock) begin
        mif.match_enable = 1'b0;
        tick();
        check("suc_one_cycle", 32'(mif.match_suc), 0);
        check("vld_held", 32'(mif.matched_vld), 1);
        check("sram_held", 32'(mif.matched_sram), idx);
        repeat ($urandom_range(0, 3)) tick();
        mif.end_of_packet = 1'b1;
        tick();
        mif.end_of_packet = 1'b0;
        check("vld_release", 32'(mif.matched_vld), 0);
        rr_m = (idx + 1) % NBank;
      end
    end else begin
      exp_sweep = (miss_cycles >= 33) ? (miss_cycles - 1) / 32 : 0;
      for (int c = 1; c <= miss_cycles; c++) begin
        tick();
        if (mif.match_suc) got = 1;
        if (mif.sweep_fail) begin
          n_sweep++;
          check("sweep_timing", 32'(c >= 33 && (c - 1) % 32 == 0), 1);
        end
      end
      check("no_suc_on_miss", 32'(got), 0);
      check("sweep_count", n_sweep, exp_sweep);
      mif.match_enable = 1'b0;
      tick();
      check("vld_after_abort", 32'(mif.matched_vld), 0);
    end
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    mif.match_enable = 1'b0;
    mif.end_of_packet = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    rr_m  = 0;
  endtask

  initial begin
    bit got;
    n_cmp = 0;
    n_bad = 0;
    rr_m  = 0;
    mif.new_length    = '0;
    mif.new_dest_port = '0;
    set_all('1, 10);
    vecs[0] = '{9'd32,  11'd4,  7,  1'b1};
    vecs[1] = '{9'd33,  11'd4,  9,  1'b0};
    vecs[2] = '{9'd33,  11'd5,  12, 1'b1};
    vecs[3] = '{9'd0,   11'd0,  3,  1'b1};
    vecs[4] = '{9'd511, 11'd64, 20, 1'b1};
    vecs[5] = '{9'd511, 11'd63, 0,  1'b0};
    vecs[6] = '{9'd8,   11'd1,  31, 1'b1};
    vecs[7] = '{9'd9,   11'd1,  16, 1'b0};

    do_reset();
    check("rst_suc", 32'(mif.match_suc), 0);
    check("rst_vld", 32'(mif.matched_vld), 0);
    check("rst_sram", 32'(mif.matched_sram), 0);
    check("rst_dest", 32'(mif.matched_dest), 0);
    check("rst_fail", 32'(mif.sweep_fail), 0);

    // First match on bank 0, then round-robin advance to bank 1.
    set_all('1, 0);
    free_v[0] = 11'd10;
    free_v[1] = 11'd10;
    run_request(9'd32, 4'd3, 40, 1'b0, got);
    run_request(9'd32, 4'd4, 40, 1'b0, got);
    check("rr_advance", rr_m, 2);

    // Single accessible bank 5: need 5 hits at free 5, misses at free 4.
    do_reset();
    set_all('0, 0);
    acc_v[5]  = 1'b1;
    free_v[5] = 11'd5;
    run_request(9'd33, 4'd9, 40, 1'b0, got);
    check("bank5_hit", 32'(got), 1);
    free_v[5] = 11'd4;
    run_request(9'd33, 4'd9, 70, 1'b0, got);

    // Abort mid-scan leaves rr untouched.
    set_all('0, 0);
    run_request(9'd16, 4'd1, 10, 1'b0, got);
    set_all('1, 20);
    run_request(9'd16, 4'd1, 40, 1'b0, got);
    check("rr_after_abort", rr_m, 7);

    // Boundary table: need rounding, single eligible bank.
    for (int i = 0; i < 8; i++) begin
      set_all('0, 0);
      acc_v[vecs[i].bank]  = 1'b1;
      free_v[vecs[i].bank] = vecs[i].free;
      run_request(vecs[i].len, 4'(i), 36, 1'b0, got);
      check("vec_hit", 32'(got), 32'(vecs[i].exp_hit));
    end

    // Lock on bank 31, end_of_packet with match_enable still high -> wrap to 0.
    do_reset();
    set_all('0, 20);
    acc_v[31] = 1'b1;
    run_request(9'd8, 4'd5, 40, 1'b1, got);
    set_all('1, 20);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("locked_no_resuc", 32'(mif.match_suc), 0);
      check("locked_sram", 32'(mif.matched_sram), 31);
    end
    mif.end_of_packet = 1'b1;
    tick();
    mif.end_of_packet = 1'b0;
    check("eop_vld", 32'(mif.matched_vld), 0);
    got = 0;
    for (int c = 1; c <= 6 && !got; c++) begin
      tick();
      if (mif.match_suc) begin
        got = 1;
        check("wrap_latency", c, 3);
        check("wrap_sram", 32'(mif.matched_sram), 0);
      end
    end
    check("wrap_seen", 32'(got), 1);
    mif.match_enable = 1'b0;
    mif.end_of_packet = 1'b1;
    tick();
    mif.end_of_packet = 1'b0;
    rr_m = 1;

    // Asynchronous reset while locked.
    run_request(9'd8, 4'd6, 40, 1'b1, got);
    #2;
    rst_n            = 1'b0;
    mif.match_enable = 1'b0;
    #1;
    check("arst_vld", 32'(mif.matched_vld), 0);
    check("arst_suc", 32'(mif.match_suc), 0);
    check("arst_sram", 32'(mif.matched_sram), 0);
    tick();
    rst_n = 1'b1;
    rr_m  = 0;
    run_request(9'd8, 4'd6, 40, 1'b0, got);
    check("post_rst_rr", rr_m, 1);

    // Randomized requests against the model.
    for (int it = 0; it < 40; it++) begin
      logic [NBank-1:0] acc;
      acc = $urandom & $urandom;
      if (it % 4 == 3) acc = acc & $urandom & $urandom & $urandom;
      acc_v = acc;
      for (int i = 0; i < NBank; i++) free_v[i] = FreeW'($urandom_range(0, 70));
      run_request(9'($urandom_range(0, 511)), 4'($urandom), $urandom_range(5, 70), 1'b0, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
